// File: rtl/argmax_stream.sv
// Streaming argmax: P lanes per beat, running max/index across N/P beats, one result per vector.
// Define ARGMAX_SIGNED_EN for two's-complement elements; otherwise compares are unsigned.
module argmax_stream #(
  parameter int N = 16,
  parameter int M = 8,
  parameter int P = 4,
  localparam int S = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M*P-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [M-1:0]   max,
  output logic [S-1:0]   ind,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int BEATS = N / P;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {ACC, HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]    acc_max_q;
  logic [S-1:0]    acc_ind_q;
  logic [M-1:0]    max_q;
  logic [S-1:0]    ind_q;

  logic            accept;
  logic            last_beat;
  logic            first;
  logic [S-1:0]    base;
  logic [M-1:0]    lane;
  logic [M-1:0]    cand_max;
  logic [S-1:0]    cand_ind;

  // True when a is strictly greater than b under the configured number format.
  function automatic logic gt(input logic [M-1:0] a, input logic [M-1:0] b);
`ifdef ARGMAX_SIGNED_EN
    logic signed [M-1:0] sa;
    logic signed [M-1:0] sb;
    sa = a;
    sb = b;
    return sa > sb;
`else
    return a > b;
`endif
  endfunction

  // Lane sweep: ">=" replacement makes ties fall to the higher index within and across beats.
  always_comb begin
    first    = (cnt_q == '0);
    base     = S'(int'(cnt_q) * P);
    lane     = '0;
    cand_max = acc_max_q;
    cand_ind = acc_ind_q;
    for (int k = 0; k < P; k++) begin
      lane = in_data[k*M +: M];
      if ((k == 0 && first) || !gt(cand_max, lane)) begin
        cand_max = lane;
        cand_ind = base + S'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_valid = (state_q == HOLD);
    in_ready  = !out_valid || out_ready;
    accept    = in_valid && in_ready;
    last_beat = accept && (cnt_q == CW'(BEATS - 1));
    if (accept) begin
      cnt_d = last_beat ? '0 : cnt_q + CW'(1);
    end
    case (state_q)
      ACC:     if (last_beat) state_d = HOLD;
      HOLD:    if (out_ready && !last_beat) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      cnt_q     <= '0;
      acc_max_q <= '0;
      acc_ind_q <= '0;
      max_q     <= '0;
      ind_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && !last_beat) begin
        acc_max_q <= cand_max;
        acc_ind_q <= cand_ind;
      end
      if (last_beat) begin
        max_q <= cand_max;
        ind_q <= cand_ind;
      end
    end
  end

  assign max = max_q;
  assign ind = ind_q;

endmodule

// File: tb/tb_argmax_stream.sv
// Self-checking bench for argmax_stream: directed vectors plus randomized traffic vs. a vector-level model.
module tb_argmax_stream;
  localparam int N     = 16;
  localparam int M     = 8;
  localparam int P     = 4;
  localparam int S     = 5;
  localparam int BEATS = N / P;

  typedef logic [M-1:0] vec_t [N];

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [M*P-1:0] in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [M-1:0]   max;
  logic [S-1:0]   ind;
  logic           out_valid;
  logic           out_ready = 1'b1;

  int compared   = 0;
  int mismatched = 0;
  bit rand_ordy  = 1'b0;
  bit started    = 1'b0;

  argmax_stream #(.N(N), .M(M), .P(P)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .max(max), .ind(ind), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: whole vectors, max by plain scan, index = last position holding the max.
  function automatic bit mgt(input logic [M-1:0] a, input logic [M-1:0] b);
`ifdef ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  vec_t         mvec;
  int           nb = 0;
  bit           exp_ov = 1'b0;
  logic [M-1:0] exp_max = '0;
  logic [S-1:0] exp_ind = '0;

  always @(posedge clk) begin : model
    bit           acc;
    bit           last;
    logic [M-1:0] best;
    int           bi;
    started = 1'b1;
    if (rst) begin
      exp_ov = 1'b0; exp_max = '0; exp_ind = '0; nb = 0;
    end else begin
      acc  = in_valid && (!exp_ov || out_ready);
      last = 1'b0;
      if (acc) begin
        for (int k = 0; k < P; k++) mvec[nb*P + k] = in_data[k*M +: M];
        nb++;
        if (nb == BEATS) begin
          nb   = 0;
          last = 1'b1;
        end
      end
      if (last) begin
        best = mvec[0];
        for (int i = 1; i < N; i++) if (mgt(mvec[i], best)) best = mvec[i];
        bi = 0;
        for (int i = 0; i < N; i++) if (mvec[i] == best) bi = i;
        exp_ov  = 1'b1;
        exp_max = best;
        exp_ind = S'(bi);
      end else if (out_ready) begin
        exp_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, !exp_ov || out_ready);
      if (exp_ov) begin
        chk("max", max, exp_max);
        chk("ind", ind, exp_ind);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [M*P-1:0] pack(input vec_t v, input int b);
    logic [M*P-1:0] d;
    for (int k = 0; k < P; k++) d[k*M +: M] = v[b*P + k];
    return d;
  endfunction

  // All drivers run at posedge+2; handshake is judged at the negedge before the edge.
  task automatic send_beat(input logic [M*P-1:0] d, input int gap);
    bit ok;
    int budget;
    repeat (gap) begin @(posedge clk); #2; end
    in_data  = d;
    in_valid = 1'b1;
    budget   = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #2;
      budget++;
    end while (!ok && budget < 200);
    if (!ok) chk("beat_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_beats(input vec_t v, input int gap, input int b0, input int b1);
    for (int b = b0; b <= b1; b++) send_beat(pack(v, b), gap);
  endtask

  task automatic wait_result(input string nm, input logic [M-1:0] em, input logic [S-1:0] ei);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
    else begin
      chk({nm, "_max"}, max, em);
      chk({nm, "_ind"}, ind, ei);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_max", max, 0);
    chk("rst_ind", ind, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #2;

    for (int i = 0; i < N; i++) v[i] = M'(i);
    send_beats(v, 0, 0, BEATS - 1);
    wait_result("ramp", 8'd15, 5'd15);

    for (int i = 0; i < N; i++) v[i] = 8'h40;
    send_beats(v, 0, 0, BEATS - 1);
    wait_result("tie", 8'h40, 5'd15);

    for (int i = 0; i < N; i++) v[i] = 8'h01;
    v[2] = 8'hFF;
    send_beats(v, 2, 0, BEATS - 1);
    wait_result("gaps", 8'hFF, 5'd2);

    // Backpressure, then release together with beat 0 of the next vector.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) v[i] = M'(i * 3);
    send_beats(v, 0, 0, BEATS - 1);
    wait_result("bp", 8'd45, 5'd15);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_max", max, 8'd45);
      chk("bp_ind", ind, 5'd15);
      @(posedge clk); #2;
    end
    for (int i = 0; i < N; i++) v[i] = 8'h01;
    v[0] = 8'h90;
    out_ready = 1'b1;
    in_data   = pack(v, 0);
    in_valid  = 1'b1;
    @(negedge clk);
    chk("release_accept", in_ready, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    send_beats(v, 0, 1, BEATS - 1);
    wait_result("release", 8'h90, 5'd0);

    // Reset mid-vector discards the partial beats.
    for (int i = 0; i < N; i++) v[i] = 8'hFF;
    send_beats(v, 0, 0, 2);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_max", max, 0);
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) v[i] = M'(8'h10 + i);
    v[9] = 8'h7A;
    send_beats(v, 0, 0, BEATS - 1);
    wait_result("after_rst", 8'h7A, 5'd9);

    for (int i = 0; i < N; i++) v[i] = 8'h00;
    v[3]  = 8'h7F;
    v[12] = 8'h80;
    send_beats(v, 1, 0, BEATS - 1);
`ifdef ARGMAX_SIGNED_EN
    wait_result("sign", 8'h7F, 5'd3);
`else
    wait_result("sign", 8'h80, 5'd12);
`endif

    rand_ordy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0:       v[i] = M'($urandom);
          1:       v[i] = M'($urandom_range(0, 3));
          default: case ($urandom_range(0, 3))
                     0: v[i] = 8'h80;
                     1: v[i] = 8'h7F;
                     2: v[i] = 8'hFF;
                     default: v[i] = 8'h00;
                   endcase
        endcase
      end
      for (int b = 0; b < BEATS; b++) send_beat(pack(v, b), $urandom_range(0, 2));
    end
    rand_ordy = 1'b0;
    @(posedge clk); #3;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
